load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: max cycles waiting for mem_gnt or mem_rvalid before error.
REQ-002 SHALL use one clock and one reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-003 SHALL have: req_valid in 1, core request present; req_ready out 1, unit can accept.
REQ-004 SHALL have: req_write in 1 (1 store, 0 load); req_funct3 in 3, RV32I access size/sign; req_addr in 32, byte address; req_wdata in 32, store data, low bits used.
REQ-005 SHALL have: resp_valid out 1, one-cycle completion pulse; resp_rdata out 32, extended load data; resp_err out 2 (00 ok, 01 misaligned, 10 timeout, 11 illegal funct3).
REQ-006 SHALL have: mem_req out 1; mem_we out 1; mem_addr out 32, word-aligned; mem_wdata out 32; mem_wstrb out 4; mem_gnt in 1; mem_rvalid in 1; mem_rdata in 32.

Function
REQ-007 SHALL implement FSM IDLE, ISSUE, WAIT_R, RESP; req_ready=1 only in IDLE.
REQ-008 SHALL accept on req_valid&&req_ready in IDLE, registering write, funct3, addr, wdata.
REQ-009 SHALL check on accept: legal loads 000/001/010/100/101, legal stores 000/001/010; else IDLE->RESP, err 11, no memory access.
REQ-010 SHALL flag misaligned on accept: half with addr[0]=1, word with addr[1:0]!=0; IDLE->RESP, err 01, no memory access; illegal funct3 takes priority.
REQ-011 SHALL otherwise go IDLE->ISSUE; in ISSUE drive mem_req=1, mem_addr={addr[31:2],2'b00}, mem_we=write.
REQ-012 SHALL hold mem_req and all mem_* outputs stable in ISSUE until mem_gnt=1.
REQ-013 SHALL on grant go to RESP (store, err 00) or WAIT_R (load); mem_req=0 outside ISSUE.
REQ-014 SHALL on store drive mem_wstrb sb 4'b0001<<addr[1:0], sh 4'b0011<<addr[1:0], sw 4'b1111; mem_wdata byte replicated x4 (sb), half replicated x2 (sh), full word (sw); mem_wstrb=0 for loads.
REQ-015 SHALL in WAIT_R capture mem_rdata when mem_rvalid=1, select byte/half lane by addr[1:0], sign-extend (lb, lh) or zero-extend (lbu, lhu), go to RESP with err 00.
REQ-016 SHALL count cycles in ISSUE and WAIT_R; cleared on entering either state; if count reaches TIMEOUT with no gnt/rvalid, go to RESP, err 10, resp_rdata 0.
REQ-017 SHALL in RESP assert resp_valid for exactly one cycle, then return to IDLE; resp_rdata and resp_err valid only while resp_valid=1, otherwise 0.
REQ-018 SHALL give latency with zero memory wait: accept cycle N, mem_req at N+1; store resp_valid N+2; load with rvalid at N+2 gives resp_valid N+3; error-on-accept resp_valid N+1.
REQ-019 SHALL ignore mem_rvalid outside WAIT_R and mem_gnt outside ISSUE.
REQ-020 SHALL have no response buffering; next accept no earlier than the cycle after resp_valid.

Reset
REQ-021 SHALL on rst=1 at a clock edge enter IDLE, clear counter and captured request, abandon any in-flight access with no response.
REQ-022 SHALL drive after reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
REQ-023 SHALL ignore req_valid in the cycle rst=1.

Structure
REQ-024 SHALL place FSM state encoding, funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and resp_err codes in shared package lsu_pkg.
REQ-025 SHALL implement lane select and extension as combinational sub-module load_extender (inputs rdata, addr[1:0], funct3; output 32-bit result).

Verification
REQ-026 SHALL cover lw at 0x10, mem_gnt immediate, rvalid next cycle, rdata 0xDEADBEEF -> resp_rdata 0xDEADBEEF, err 00, resp_valid at N+3.
REQ-027 SHALL cover lb at 0x13, rdata 0x80FF1234 -> 0xFFFFFF80; lbu same -> 0x00000080; lhu at 0x12 -> 0x000080FF.
REQ-028 SHALL cover sb at 0x21, wdata 0x000000AB, gnt delayed 3 cycles -> mem_addr 0x20, wstrb 0010, wdata 0xABABABAB held 4 cycles, resp err 00.
REQ-029 SHALL cover lh at 0x03 -> err 01 at N+1, mem_req never asserted; funct3 011 load -> err 11.
REQ-030 SHALL cover TIMEOUT=4, mem_gnt held 0 -> mem_req 4 cycles, resp err 10, resp_rdata 0; then rst mid-WAIT_R -> no resp_valid, req_ready=1 next cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, RV32I funct3 codes,
// response error codes and the request legality helpers used at accept time.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

    // Load access sizes / signedness
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store access sizes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Response error codes
    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    // True when funct3 names a supported access for the given direction.
    function automatic logic funct3_legal(input logic write, input logic [2:0] funct3);
        logic ok;
        ok = 1'b0;
        if (write) begin
            ok = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        end else begin
            ok = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                 (funct3 == F3_LBU) || (funct3 == F3_LHU);
        end
        return ok;
    endfunction

    // funct3[1:0] encodes the size for every legal access: 00 byte, 01 half, 10 word.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (funct3[1:0])
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_extender.sv
// Picks the addressed byte/half lane out of a memory word and sign- or
// zero-extends it according to the load funct3.
module load_extender
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane select followed by extension; words pass straight through.
    always_comb begin
        byte_lane = rdata[{addr_lo, 3'b000} +: 8];
        half_lane = rdata[{addr_lo[1], 4'b0000} +: 16];
        result    = rdata;
        case (funct3)
            F3_LB:   result = {{24{byte_lane[7]}}, byte_lane};
            F3_LBU:  result = {24'h000000, byte_lane};
            F3_LH:   result = {{16{half_lane[15]}}, half_lane};
            F3_LHU:  result = {16'h0000, half_lane};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: accepts one core request, checks it,
// performs at most one memory access with grant/read-data timeouts, and
// returns a one-cycle response pulse.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    lsu_state_e  state_q, state_d;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] ext_result;
    logic        accept;

    assign accept = (state_q == ST_IDLE) && req_valid;

    load_extender u_load_extender (
        .rdata   (mem_rdata),
        .addr_lo (addr_q[1:0]),
        .funct3  (funct3_q),
        .result  (ext_result)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state, wait counter, response data/code, and all outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        resp_err   = ERR_OK;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        mem_wstrb  = 4'b0000;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    rdata_d = 32'h0;
                    cnt_d   = '0;
                    if (!funct3_legal(req_write, req_funct3)) begin
                        state_d = ST_RESP;
                        err_d   = ERR_ILLEGAL;
                    end else if (is_misaligned(req_funct3, req_addr[1:0])) begin
                        state_d = ST_RESP;
                        err_d   = ERR_MISALIGN;
                    end else begin
                        state_d = ST_ISSUE;
                        err_d   = ERR_OK;
                    end
                end
            end
            ST_ISSUE: begin
                mem_req  = 1'b1;
                mem_we   = write_q;
                mem_addr = {addr_q[31:2], 2'b00};
                if (write_q) begin
                    case (funct3_q)
                        F3_SB: begin
                            mem_wstrb = 4'b0001 << addr_q[1:0];
                            mem_wdata = {4{wdata_q[7:0]}};
                        end
                        F3_SH: begin
                            mem_wstrb = 4'b0011 << addr_q[1:0];
                            mem_wdata = {2{wdata_q[15:0]}};
                        end
                        default: begin
                            mem_wstrb = 4'b1111;
                            mem_wdata = wdata_q;
                        end
                    endcase
                end
                if (mem_gnt) begin
                    cnt_d   = '0;
                    state_d = write_q ? ST_RESP : ST_WAIT_R;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RESP;
                    err_d   = ERR_TIMEOUT;
                    rdata_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WAIT_R: begin
                if (mem_rvalid) begin
                    rdata_d = ext_result;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RESP;
                    err_d   = ERR_TIMEOUT;
                    rdata_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_err   = err_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Captured request, wait counter and pending response contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            cnt_q    <= '0;
            rdata_q  <= 32'h0;
            err_q    <= ERR_OK;
        end else begin
            if (accept) begin
                write_q  <= req_write;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed bench for load_store_unit. The stimulus task plays
// both core and memory, pushes each expected response into a queue, and an
// independent monitor pops and compares whenever resp_valid is seen.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        int          due;
    } exp_t;

    exp_t exp_q[$];

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit refLegal(bit w, int f3);
        if (w) return (f3 <= 2);
        return (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    endfunction

    function automatic int refSize(int f3);
        return 1 << (f3 % 4);
    endfunction

    function automatic logic [31:0] refLoad(int f3, logic [31:0] a, logic [31:0] d);
        int     size;
        longint off, v, span;
        size = refSize(f3);
        if (size == 4) return d;
        off  = longint'(a % 4);
        span = longint'(1) << (8 * size);
        v    = (longint'(d) >> (8 * off)) % span;
        if (f3 < 4 && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    function automatic logic [3:0] refStrb(int f3, logic [31:0] a);
        int s;
        s = refSize(f3);
        return 4'((((1 << s) - 1) << (a % 4)) & 15);
    endfunction

    function automatic logic [31:0] refWdata(int f3, logic [31:0] wd);
        int s;
        s = refSize(f3);
        if (s == 1) return (wd % 256) * 32'h01010101;
        if (s == 2) return (wd % 65536) * 32'h00010001;
        return wd;
    endfunction

    // ---------------- response monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("resp_rdata", resp_rdata, e.rdata);
                checkOutput("resp_err", {30'd0, resp_err}, {30'd0, e.err});
                checkOutput("resp_cycle", cyc, e.due);
            end
        end else begin
            checkOutput("idle_resp_rdata", resp_rdata, 32'h0);
            checkOutput("idle_resp_err", {30'd0, resp_err}, 32'h0);
        end
    end

    // ---------------- stimulus ----------------
    // Call just after a rising edge with the unit idle. g = ISSUE cycles
    // before grant, r = WAIT_R cycles before rvalid; >= TO means never.
    task automatic applyStimulus(input bit w, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input int g, input int r,
                                 input logic [31:0] rd);
        int   n, base, k;
        exp_t e;
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(negedge clk);
        checkOutput("req_ready", {31'd0, req_ready}, 32'd1);
        base = cyc;
        if (!refLegal(w, int'(f3)) || (a % refSize(int'(f3))) != 0) begin
            e.rdata = 32'h0;
            e.err   = refLegal(w, int'(f3)) ? 2'b01 : 2'b11;
            e.due   = base + 1;
            exp_q.push_back(e);
            @(posedge clk); #1;
            req_valid = 1'b0;
            @(negedge clk);
            checkOutput("err_no_mem_req", {31'd0, mem_req}, 32'd0);
        end else begin
            e.err   = 2'b00;
            e.rdata = 32'h0;
            if (g >= TO) begin
                e.err = 2'b10;
                e.due = base + 1 + TO;
            end else if (w) begin
                e.due = base + 2 + g;
            end else if (r >= TO) begin
                e.err = 2'b10;
                e.due = base + 2 + g + TO;
            end else begin
                e.rdata = refLoad(int'(f3), a, rd);
                e.due   = base + 3 + g + r;
            end
            exp_q.push_back(e);
            n = (g < TO) ? g + 1 : TO;
            for (int i = 0; i < n; i++) begin
                @(posedge clk); #1;
                req_valid  = 1'b0;
                mem_gnt    = (i == g);
                mem_rvalid = 1'($urandom_range(0, 1));
                mem_rdata  = $urandom;
                @(negedge clk);
                checkOutput("mem_req", {31'd0, mem_req}, 32'd1);
                checkOutput("mem_we", {31'd0, mem_we}, {31'd0, w});
                checkOutput("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
                checkOutput("mem_wstrb", {28'd0, mem_wstrb}, w ? {28'd0, refStrb(int'(f3), a)} : 32'd0);
                if (w) checkOutput("mem_wdata", mem_wdata, refWdata(int'(f3), wd));
            end
            if (!w && g < TO) begin
                n = (r < TO) ? r + 1 : TO;
                for (int j = 0; j < n; j++) begin
                    @(posedge clk); #1;
                    mem_gnt    = 1'($urandom_range(0, 1));
                    mem_rvalid = (j == r);
                    mem_rdata  = (j == r) ? rd : $urandom;
                    @(negedge clk);
                    checkOutput("wait_mem_req", {31'd0, mem_req}, 32'd0);
                end
            end
            @(posedge clk); #1;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
        end
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (exp_q.size() != 0 && k < TO + 12);
        if (exp_q.size() != 0) begin
            checkOutput("resp_never_seen", exp_q.size(), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        bit          w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [2:0]  legal_loads [5];
        legal_loads = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        rst        = 1'b1;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h100;
        req_wdata  = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;

        // Reset with a request pending: it must be ignored.
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_mem_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;

        // Directed cases.
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 0, 0, 32'hDEADBEEF);
        applyStimulus(1'b0, 3'b000, 32'h13, 32'h0, 0, 0, 32'h80FF1234);
        applyStimulus(1'b0, 3'b100, 32'h13, 32'h0, 0, 0, 32'h80FF1234);
        applyStimulus(1'b0, 3'b101, 32'h12, 32'h0, 0, 1, 32'h80FF1234);
        applyStimulus(1'b0, 3'b001, 32'h12, 32'h0, 1, 2, 32'h80FF1234);
        applyStimulus(1'b1, 3'b000, 32'h21, 32'h000000AB, 3, 0, 32'h0);
        applyStimulus(1'b1, 3'b001, 32'h22, 32'h1234CDEF, 1, 0, 32'h0);
        applyStimulus(1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 0, 0, 32'h0);
        applyStimulus(1'b0, 3'b001, 32'h03, 32'h0, 0, 0, 32'h0);
        applyStimulus(1'b0, 3'b011, 32'h40, 32'h0, 0, 0, 32'h0);
        applyStimulus(1'b1, 3'b100, 32'h41, 32'h0, 0, 0, 32'h0);
        applyStimulus(1'b0, 3'b010, 32'h44, 32'h0, TO, 0, 32'h0);
        applyStimulus(1'b0, 3'b010, 32'h48, 32'h0, 0, TO, 32'h12345678);

        // Reset in the middle of WAIT_R: the access is dropped silently.
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h50;
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        rst     = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(posedge clk); #1;

        // Randomized traffic.
        for (int t = 0; t < 80; t++) begin
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
            else if (w) f3 = 3'($urandom_range(0, 2));
            else f3 = legal_loads[$urandom_range(0, 4)];
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(refSize(int'(f3)) - 1);
            applyStimulus(w, f3, a, $urandom, $urandom_range(0, TO + 1),
                          $urandom_range(0, TO + 1), $urandom);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
